// File: rtl/eeprom_writeback.sv
// Bus-master sequencer copying the RAM image back into a page-write EEPROM.
// Optional software-data-protection unlock prefix per page: define EEPROM_SDP_EN.
module eeprom_writeback #(
   parameter int PAGE_BYTES         = 64,
   parameter int DEPTH              = 8192,
   parameter int WRITE_CYCLE_CLOCKS = 10000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        bus_grant,
   output logic        bus_req,
   output logic        busy,
   output logic        done,
   output logic        error,
   inout  wire  [15:0] address,
   inout  wire  [7:0]  data,
   inout  wire         ram_cs_n,
   inout  wire         ram_oe_n,
   inout  wire         eeprom_cs_n,
   inout  wire         eeprom_we_n,
   inout  wire         eeprom_oe_n
);

   localparam int CW = (WRITE_CYCLE_CLOCKS > 1) ? $clog2(WRITE_CYCLE_CLOCKS) : 1;
   localparam logic [12:0] PAGE_MASK   = 13'(PAGE_BYTES - 1);
   localparam logic [12:0] LAST_OFFSET = 13'(DEPTH - 1);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_REQ    = 4'd1;
   localparam logic [3:0] S_SETUP  = 4'd2;
   localparam logic [3:0] S_STROBE = 4'd3;
   localparam logic [3:0] S_HOLD   = 4'd4;
   localparam logic [3:0] S_WAIT   = 4'd5;
   localparam logic [3:0] S_SDP1   = 4'd6;
   localparam logic [3:0] S_SDP2   = 4'd7;
   localparam logic [3:0] S_SDP3   = 4'd8;

`ifdef EEPROM_SDP_EN
   localparam logic [3:0] S_PAGE = S_SDP1;
`else
   localparam logic [3:0] S_PAGE = S_SETUP;
`endif

   logic [3:0]    state;
   logic [12:0]   offset;
   logic [CW-1:0] wait_cnt;
   logic          page_end;
   logic          last_byte;
   logic          owned;
   logic          sdp;
   logic          we_low;
   logic [15:0]   addr_mux;

`ifdef EEPROM_SDP_EN
   logic [1:0] phase;
   logic [7:0] sdp_byte;
`endif

   assign page_end  = &(offset | ~PAGE_MASK);
   assign last_byte = (offset == LAST_OFFSET);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         offset   <= '0;
         wait_cnt <= '0;
         error    <= 1'b0;
`ifdef EEPROM_SDP_EN
         phase    <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: if (start) begin
               error  <= 1'b0;
               offset <= '0;
               state  <= S_REQ;
`ifdef EEPROM_SDP_EN
               phase  <= '0;
`endif
            end
            S_REQ: if (bus_grant) state <= S_PAGE;
            default: begin
               // Losing the grant in any owned state abandons the copy outright.
               if (!bus_grant) begin
                  error <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  case (state)
                     S_SETUP:  state <= S_STROBE;
                     S_STROBE: state <= S_HOLD;
                     S_HOLD: begin
                        if (page_end) begin
                           wait_cnt <= CW'(WRITE_CYCLE_CLOCKS - 1);
                           state    <= S_WAIT;
                        end else begin
                           offset <= offset + 13'd1;
                           state  <= S_SETUP;
                        end
                     end
                     S_WAIT: begin
                        if (wait_cnt == '0) begin
                           if (last_byte) begin
                              state <= S_IDLE;
                           end else begin
                              offset <= offset + 13'd1;
                              state  <= S_PAGE;
                           end
                        end else begin
                           wait_cnt <= wait_cnt - CW'(1);
                        end
                     end
`ifdef EEPROM_SDP_EN
                     S_SDP1, S_SDP2, S_SDP3: begin
                        if (phase == 2'd2) begin
                           phase <= '0;
                           case (state)
                              S_SDP1:  state <= S_SDP2;
                              S_SDP2:  state <= S_SDP3;
                              default: state <= S_SETUP;
                           endcase
                        end else begin
                           phase <= phase + 2'd1;
                        end
                     end
`endif
                     default: state <= S_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   assign owned   = (state != S_IDLE) && (state != S_REQ);
   assign bus_req = (state != S_IDLE);
   assign busy    = (state != S_IDLE);
   assign done    = (state == S_WAIT) && (wait_cnt == '0) && last_byte && bus_grant;

`ifdef EEPROM_SDP_EN
   assign sdp      = (state == S_SDP1) || (state == S_SDP2) || (state == S_SDP3);
   assign we_low   = (state == S_STROBE) || (sdp && phase == 2'd1);
   assign sdp_byte = (state == S_SDP1) ? 8'hAA : (state == S_SDP2) ? 8'h55 : 8'hA0;
   assign addr_mux = !sdp ? {3'b000, offset} : (state == S_SDP2) ? 16'h0AAA : 16'h1555;
   assign data     = sdp ? sdp_byte : 8'bz;
`else
   assign sdp      = 1'b0;
   assign we_low   = (state == S_STROBE);
   assign addr_mux = {3'b000, offset};
   assign data     = 8'bz;
`endif

   // RAM sources data for page bytes; during WAIT the EEPROM is deselected so it can self-program.
   assign address     = owned ? addr_mux : 16'bz;
   assign ram_cs_n    = owned ? sdp : 1'bz;
   assign ram_oe_n    = owned ? (sdp || state == S_WAIT) : 1'bz;
   assign eeprom_cs_n = owned ? (state == S_WAIT) : 1'bz;
   assign eeprom_we_n = owned ? !we_low : 1'bz;
   assign eeprom_oe_n = owned ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_eeprom_writeback.sv
// Scoreboard bench for eeprom_writeback: expected EEPROM writes and run lengths are queued
// at stimulus time and consumed by a negedge bus monitor.
module tb_eeprom_writeback;
   localparam int DEPTH = 128;
   localparam int PAGE  = 64;
   localparam int WCC   = 4;
`ifdef EEPROM_SDP_EN
   localparam int SDP_CLKS = 9;
`else
   localparam int SDP_CLKS = 0;
`endif
   localparam int RUN_CLKS = (DEPTH / PAGE) * (3 * PAGE + WCC + SDP_CLKS);

   logic clock, reset_n, start, bus_grant;
   logic bus_req, busy, done, error;
   wire [15:0] address;
   wire [7:0]  data;
   wire ram_cs_n, ram_oe_n, eeprom_cs_n, eeprom_we_n, eeprom_oe_n;

   pullup (address);
   pullup (ram_cs_n);
   pullup (ram_oe_n);
   pullup (eeprom_cs_n);
   pullup (eeprom_we_n);
   pullup (eeprom_oe_n);

   logic [7:0] ram_mem [0:DEPTH-1];
   logic [7:0] ee_mem  [0:DEPTH-1];
   assign data = (!ram_cs_n && !ram_oe_n) ? ram_mem[address[6:0]] : 8'bz;

   eeprom_writeback #(.PAGE_BYTES(PAGE), .DEPTH(DEPTH), .WRITE_CYCLE_CLOCKS(WCC)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .bus_grant(bus_grant),
      .bus_req(bus_req), .busy(busy), .done(done), .error(error),
      .address(address), .data(data), .ram_cs_n(ram_cs_n), .ram_oe_n(ram_oe_n),
      .eeprom_cs_n(eeprom_cs_n), .eeprom_we_n(eeprom_we_n), .eeprom_oe_n(eeprom_oe_n));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int tests = 0, fails = 0;
   logic [23:0] exp_wr_q [$];
   int exp_done_q [$];
   int grant_delay = 0, gcnt = 0;
   logic drop = 1'b0;
   int owned_cyc = 0, req_wait = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic released();
      return (address == 16'hFFFF) && ram_cs_n && ram_oe_n && eeprom_cs_n && eeprom_we_n && eeprom_oe_n;
   endfunction

   // Grant model: grants grant_delay cycles after bus_req, withdrawn when drop is set.
   initial begin
      bus_grant = 1'b0;
      forever begin
         @(posedge clock); #1;
         if (!bus_req || drop) begin
            bus_grant = 1'b0;
            if (!bus_req) gcnt = 0;
         end else if (gcnt >= grant_delay) bus_grant = 1'b1;
         else gcnt++;
      end
   end

   // Bus monitor / scoreboard.
   initial begin
      logic [15:0] prev_addr, hold_addr;
      logic hold_chk, prev_done;
      int wait_len;
      logic [23:0] e;
      prev_addr = 16'hFFFF; hold_addr = '0; hold_chk = 1'b0; prev_done = 1'b0; wait_len = 0;
      forever begin
         @(negedge clock);
         if (!reset_n) continue;
         if (address != 16'hFFFF) owned_cyc++;
         if (bus_req && !bus_grant && !drop) begin
            req_wait++;
            chk("drive_before_grant", {31'd0, released()}, 32'd1);
         end
         if (!eeprom_we_n && !eeprom_cs_n) begin
            if (exp_wr_q.size() == 0) chk("unexpected_write", {8'd0, address, data}, 32'd0);
            else begin
               e = exp_wr_q.pop_front();
               chk("write_addr_data", {address, data}, e);
            end
            chk("addr_setup", {16'd0, prev_addr}, {16'd0, address});
            if (address < 16'(DEPTH)) ee_mem[address[6:0]] = data;
            hold_chk = 1'b1; hold_addr = address;
         end else if (hold_chk) begin
            hold_chk = 1'b0;
            if (!drop) chk("addr_hold", {15'd0, eeprom_we_n, address}, {15'd0, 1'b1, hold_addr});
         end
         if (address != 16'hFFFF && eeprom_cs_n) wait_len++;
         else if (wait_len > 0) begin
            chk("wait_len", wait_len, WCC);
            wait_len = 0;
         end
         if (prev_done) begin
            prev_done = 1'b0;
            chk("busy_after_done", {30'd0, busy, released()}, 32'd1);
         end
         if (done) begin
            if (exp_done_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else chk("run_clocks", owned_cyc, exp_done_q.pop_front());
            chk("done_state", {29'd0, busy, error, 1'(exp_wr_q.size())}, 32'd4);
            owned_cyc = 0;
            prev_done = 1'b1;
         end
         prev_addr = address;
      end
   end

   task automatic fill_ram(input int mul, input int add);
      for (int i = 0; i < DEPTH; i++) ram_mem[i] = 8'(i * mul + add);
   endtask

   task automatic push_run(input int upto);
      for (int o = 0; o <= upto; o++) begin
`ifdef EEPROM_SDP_EN
         if (o % PAGE == 0) begin
            exp_wr_q.push_back({16'h1555, 8'hAA});
            exp_wr_q.push_back({16'h0AAA, 8'h55});
            exp_wr_q.push_back({16'h1555, 8'hA0});
         end
`endif
         exp_wr_q.push_back({16'(o), ram_mem[o]});
      end
   endtask

   task automatic pulse_start();
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 3000) begin @(negedge clock); n++; end
      if (busy) chk({name, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic check_image(input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (ee_mem[i] !== ram_mem[i]) bad++;
      chk(name, bad, 0);
   endtask

   initial begin
      int n;
      reset_n = 1'b0; start = 1'b1;
      for (int i = 0; i < DEPTH; i++) ee_mem[i] = 8'h00;
      repeat (4) @(posedge clock);
      @(negedge clock);
      chk("reset_pins_z", {31'd0, released()}, 32'd1);
      chk("reset_outputs", {28'd0, bus_req, busy, done, error}, 32'd0);
      @(posedge clock); #1 reset_n = 1'b1; start = 1'b0;
      repeat (4) @(negedge clock);
      chk("no_req_without_start", {31'd0, bus_req}, 32'd0);

      // Full copy, immediate grant.
      fill_ram(7, 3);
      push_run(DEPTH - 1); exp_done_q.push_back(RUN_CLKS);
      pulse_start();
      wait_idle("run1");
      check_image("image_run1");
      chk("run1_error", {31'd0, error}, 32'd0);

      // Grant withdrawn at offset 0x45.
      fill_ram(13, 91);
      push_run(16'h0045);
      pulse_start();
      n = 0;
      while (!(address == 16'h0045 && !ram_cs_n) && n < 3000) begin @(negedge clock); n++; end
      if (n >= 3000) chk("abort_addr_timeout", 32'd1, 32'd0);
      drop = 1'b1;
      @(negedge clock);
      @(negedge clock);
      chk("abort_release", {30'd0, released(), error}, 32'd3);
      wait_idle("abort");
      chk("abort_pending_writes", exp_wr_q.size(), 0);
      owned_cyc = 0;
      @(posedge clock); #1 drop = 1'b0;
      push_run(DEPTH - 1); exp_done_q.push_back(RUN_CLKS);
      pulse_start();
      @(negedge clock);
      chk("error_cleared", {31'd0, error}, 32'd0);
      wait_idle("run2");
      check_image("image_run2");

      // start pulsed during WAIT is ignored.
      fill_ram(29, 5);
      push_run(DEPTH - 1); exp_done_q.push_back(RUN_CLKS);
      pulse_start();
      n = 0;
      while (!(address != 16'hFFFF && eeprom_cs_n) && n < 3000) begin @(negedge clock); n++; end
      if (n >= 3000) chk("wait_timeout", 32'd1, 32'd0);
      pulse_start();
      wait_idle("run3");
      repeat (3) @(negedge clock);
      chk("start_in_wait_ignored", {30'd0, busy, bus_req}, 32'd0);
      check_image("image_run3");

      // Delayed grant.
      fill_ram(3, 200);
      grant_delay = 20; req_wait = 0;
      push_run(DEPTH - 1); exp_done_q.push_back(RUN_CLKS);
      pulse_start();
      wait_idle("run4");
      chk("req_wait_cycles", req_wait, 20);
      check_image("image_run4");
      grant_delay = 0;

      repeat (3) @(negedge clock);
      chk("done_queue_empty", exp_done_q.size(), 0);
      chk("write_queue_empty", exp_wr_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/eeprom_writeback.md
# eeprom_writeback

Bus-master sequencer that copies an 8 KB RAM image back into the boot EEPROM (28C64-class, 64-byte page write), the reverse of the boot-time EEPROM→RAM copy. Sits beside the CPU on the shared address/control bus. On a `start` pulse it requests the bus, streams RAM bytes into EEPROM page buffers, waits out each internal write cycle, then releases the bus and reports `done`.

## Interface
- `PAGE_BYTES`, 64: EEPROM page size; power of two, divides `DEPTH`.
- `DEPTH`, 8192: bytes copied; power of two, ≤ 8192.
- `WRITE_CYCLE_CLOCKS`, 10000: wait after each page (10 ms at 1 MHz).
- `clock`  in  1  system clock, 1 MHz nominal.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a writeback.
- `bus_grant`  in  1  CPU has released the bus (BE low); must stay high while owned.
- `bus_req`  out  1  bus request to CPU logic.
- `busy`  out  1  high from accepted `start` until return to IDLE.
- `done`  out  1  one-cycle pulse on successful completion.
- `error`  out  1  sticky; set on grant loss, cleared by the next accepted `start`.
- `address`  inout  16  `{3'b0, offset}`; Z when not owning the bus.
- `data`  inout  8  driven only during SDP unlock writes, else Z.
- `ram_cs_n`, `ram_oe_n`, `eeprom_cs_n`, `eeprom_we_n`, `eeprom_oe_n`  inout  1 each  strobes; Z when not owning.

## Operation
- States: IDLE, REQ, SETUP, STROBE, HOLD, WAIT, (SDP1–SDP3 with `EEPROM_SDP_EN`).
- IDLE: all bus pins Z, `bus_req`=0. `start`=1 → clear `error`, offset←0, REQ. `start` while not IDLE ignored.
- REQ: `bus_req`=1; on `bus_grant`=1 → SETUP (or SDP1).
- Owned bus: `eeprom_oe_n`=1, `ram_cs_n`=0, `ram_oe_n`=0 (RAM drives `data`), `eeprom_cs_n`=0, `address`=offset.
- SETUP (1 cycle): address stable, `eeprom_we_n`=1.
- STROBE (1 cycle): `eeprom_we_n`=0.
- HOLD (1 cycle): `eeprom_we_n`=1, address held. Then: if offset[page bits] all ones → WAIT; else offset+1 → SETUP.
- WAIT: counter loads `WRITE_CYCLE_CLOCKS`-1, decrements to 0; during WAIT `eeprom_cs_n`=1, `ram_oe_n`=1. At 0: if offset = `DEPTH`-1 → `done`=1, IDLE; else offset+1 → SETUP (or SDP1).
- `bus_grant` falling in any owned state: release pins to Z next cycle, `error`=1, IDLE, no `done`.
- Offset is 13 bits; wrap from `DEPTH`-1 never occurs (terminates first).

## Timing
- Reset: `bus_req`=0, `busy`=0, `done`=0, `error`=0, all inout pins Z, state IDLE; reset mid-copy aborts immediately without `done`.
- `start` → `bus_req`=1 the next cycle; grant sampled each cycle.
- Per byte: 3 clocks (SETUP, STROBE, HOLD); inter-byte gap 3 µs at 1 MHz, within EEPROM byte-load limit.
- WE low exactly 1 clock; address and RAM data stable 1 clock before and after.
- Per page (no SDP): 3·`PAGE_BYTES` + `WRITE_CYCLE_CLOCKS` clocks. Total default: 128·(192+10000)=1,304,576 clocks after grant.
- `done` coincides with first IDLE cycle's predecessor; `busy` falls the cycle after `done`.

## Configuration
- `EEPROM_SDP_EN` defined: before each page, SDP1–SDP3 each run a SETUP/STROBE/HOLD triplet writing 0xAA@0x1555, 0x55@0x0AAA, 0xA0@0x1555 with `ram_oe_n`=1, `ram_cs_n`=1 and the block driving `data`; adds 9 clocks per page.
- Undefined: no SDP states, `data` permanently Z.

## Test plan
- Reset with `start`=1 held → all pins Z, `busy`=0, no `bus_req` until reset released and new `start`.
- `DEPTH`=128, `PAGE_BYTES`=64, `WRITE_CYCLE_CLOCKS`=4, grant immediate → 128 WE pulses at addresses 0x0000–0x007F, two WAITs of 4 clocks, `done` once, EEPROM model equals RAM model.
- Same, with `bus_grant` dropped at offset 0x0045 → pins Z next cycle, `error`=1, no `done`; next `start` clears `error` and completes.
- `start` pulsed during WAIT → ignored; exactly one `done`.
- Grant delayed 20 cycles → `bus_req` high 20 cycles, no bus pin driven before grant.
- With `EEPROM_SDP_EN`: each page preceded by writes 0xAA@0x1555, 0x55@0x0AAA, 0xA0@0x1555; page time 3·64+9+4 clocks.
